// File: rtl/bram_burst_master_if.sv
// Command, write-data, read-return and BRAM port signals of one burst master.
// The master modport is the controller's side; the slave modport is its environment.
interface bram_burst_master_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] cmd_len;
    logic              wdata_valid;
    logic              wdata_ready;
    logic [DATA_W-1:0] wdata;
    logic              rdata_valid;
    logic              rdata_ready;
    logic [DATA_W-1:0] rdata;
    logic              rdata_last;
    logic              done;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic [DATA_W-1:0] mem_dout;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len,
        input  wdata_valid, wdata, rdata_ready, mem_dout,
        output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
        output mem_en, mem_we, mem_addr, mem_din
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len,
        output wdata_valid, wdata, rdata_ready, mem_dout,
        input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done,
        input  mem_en, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/bram_burst_master.sv
// Burst master for one BRAM port: converts burst commands into per-cycle strobes and
// returns read data through a credit-tracked FIFO so consumer stalls never drop words.
module bram_burst_master #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 16,
    parameter int RD_LAT     = 1,
    parameter int FIFO_DEPTH = 4
) (
    input logic                 clk,
    input logic                 rst,
    bram_burst_master_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [CW-1:0]     ONE_C = 1;
    localparam logic [PW-1:0]     ONE_P = 1;
    localparam logic [PW-1:0]     LAST_P = PW'(FIFO_DEPTH - 1);
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;
    state_t state;

    logic [ADDR_W-1:0] addr, len_q, beats_left, ret_idx;
    logic              cmd_ready_q, done_q, mem_en_q, mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_din_q;

    logic [RD_LAT:0]   pipe;
    logic [CW-1:0]     inflight, count;
    logic [PW-1:0]     wptr, rptr;
    logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
    logic [CW:0]       outstanding;
    logic              cmd_hs, wbeat, issue, push, pop, head_last, head_valid;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_P) ? '0 : p + ONE_P;
    endfunction

    // Credits cover both words still in the memory pipeline and words parked in the FIFO.
    assign outstanding = {1'b0, count} + {1'b0, inflight};
    assign cmd_hs      = (state == IDLE) && bus.cmd_valid && cmd_ready_q;
    assign wbeat       = (state == WRITE) && bus.wdata_valid;
    assign issue       = (state == READ) && (outstanding < DEPTH_C);
    assign push        = pipe[RD_LAT];
    assign head_valid  = (count != '0);
    assign pop         = head_valid && bus.rdata_ready;
    assign head_last   = fifo_mem[rptr][DATA_W];

    assign bus.cmd_ready   = cmd_ready_q;
    assign bus.wdata_ready = (state == WRITE);
    assign bus.rdata_valid = head_valid;
    assign bus.rdata       = head_valid ? fifo_mem[rptr][DATA_W-1:0] : '0;
    assign bus.rdata_last  = head_valid && head_last;
    assign bus.done        = done_q;
    assign bus.mem_en      = mem_en_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_din     = mem_din_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            addr        <= '0;
            len_q       <= '0;
            beats_left  <= '0;
            cmd_ready_q <= 1'b0;
            done_q      <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
        end else begin
            done_q   <= 1'b0;
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready_q <= 1'b1;
                    if (cmd_hs) begin
                        addr        <= bus.cmd_addr;
                        len_q       <= bus.cmd_len;
                        beats_left  <= bus.cmd_len;
                        cmd_ready_q <= 1'b0;
                        state       <= bus.cmd_write ? WRITE : READ;
                    end
                end
                WRITE: begin
                    if (wbeat) begin
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b1;
                        mem_addr_q <= addr;
                        mem_din_q  <= bus.wdata;
                        addr       <= addr + ONE_A;
                        beats_left <= beats_left - ONE_A;
                        if (beats_left == '0) begin
                            state       <= IDLE;
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= addr;
                        addr       <= addr + ONE_A;
                        beats_left <= beats_left - ONE_A;
                        if (beats_left == '0) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The tagged last beat leaving the FIFO means every earlier word already left.
                    if (pop && head_last && (inflight == '0)) begin
                        state       <= IDLE;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe     <= '0;
            inflight <= '0;
            count    <= '0;
            wptr     <= '0;
            rptr     <= '0;
            ret_idx  <= '0;
        end else begin
            pipe <= {pipe[RD_LAT-1:0], issue};
            if (issue && !push)      inflight <= inflight + ONE_C;
            else if (!issue && push) inflight <= inflight - ONE_C;
            if (push && !pop)        count <= count + ONE_C;
            else if (!push && pop)   count <= count - ONE_C;
            if (push) begin
                wptr    <= ptr_next(wptr);
                ret_idx <= ret_idx + ONE_A;
            end
            if (pop)    rptr    <= ptr_next(rptr);
            if (cmd_hs) ret_idx <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wptr] <= {(ret_idx == len_q), bus.mem_dout};
    end
endmodule
